// File: rtl/risc_pkg.sv
// Shared definitions for the IITB-RISC IF/ID/EX core: opcodes, decoded
// operation and format enums, condition codes and the decode helpers.
package risc_pkg;

    localparam int RISC_WIDTH = 16;

    localparam logic [3:0] OP_ADI = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_JAL = 4'b1001;
    localparam logic [3:0] OP_JLR = 4'b1010;

    // Condition / modifier field in instr[1:0]
    localparam logic [1:0] CZ_NONE  = 2'b00;
    localparam logic [1:0] CZ_ZERO  = 2'b01;
    localparam logic [1:0] CZ_CARRY = 2'b10;
    localparam logic [1:0] CZ_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_J   = 2'b10,
        FMT_NOP = 2'b11
    } rij_t;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_ADC, ALU_ADZ, ALU_ADL, ALU_ADI,
        ALU_NDU, ALU_NDC, ALU_NDZ, ALU_LHI,
        ALU_BEQ, ALU_JAL, ALU_JLR, ALU_NOP
    } alu_op_t;

    function automatic alu_op_t decode_op(input logic [15:0] instr);
        alu_op_t op;
        op = ALU_NOP;
        case (instr[15:12])
            OP_ADD: begin
                case (instr[1:0])
                    CZ_NONE:  op = ALU_ADD;
                    CZ_CARRY: op = ALU_ADC;
                    CZ_ZERO:  op = ALU_ADZ;
                    CZ_SHIFT: op = ALU_ADL;
                endcase
            end
            OP_NDU: begin
                case (instr[1:0])
                    CZ_NONE:  op = ALU_NDU;
                    CZ_CARRY: op = ALU_NDC;
                    CZ_ZERO:  op = ALU_NDZ;
                    CZ_SHIFT: op = ALU_NOP;
                endcase
            end
            OP_ADI:  op = ALU_ADI;
            OP_LHI:  op = ALU_LHI;
            OP_BEQ:  op = ALU_BEQ;
            OP_JAL:  op = ALU_JAL;
            OP_JLR:  op = ALU_JLR;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

    function automatic rij_t decode_fmt(input alu_op_t op);
        rij_t fmt;
        case (op)
            ALU_ADD, ALU_ADC, ALU_ADZ, ALU_ADL,
            ALU_NDU, ALU_NDC, ALU_NDZ:          fmt = FMT_R;
            ALU_ADI, ALU_BEQ, ALU_JLR:          fmt = FMT_I;
            ALU_LHI, ALU_JAL:                   fmt = FMT_J;
            default:                            fmt = FMT_NOP;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/instr_fetch_decode_execute_if.sv
// Bus bundle between the core and its surroundings: instruction memory,
// write-back observation, flags, flush and the register debug port.
interface instr_fetch_decode_execute_if
    import risc_pkg::*;
#(
    parameter int WIDTH = RISC_WIDTH
);
    logic             flush;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic             update;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             c_flag;
    logic             z_flag;
    logic [2:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        input  flush, imem_rdata, dbg_addr,
        output imem_addr, update, wr_addr, wr_data, c_flag, z_flag, dbg_data
    );

    modport slave (
        output flush, imem_rdata, dbg_addr,
        input  imem_addr, update, wr_addr, wr_data, c_flag, z_flag, dbg_data
    );
endinterface

// File: rtl/risc_alu.sv
// Combinational ALU for the EX stage: add (optionally with B shifted left
// by one) producing carry-out, NAND, zero detect on the result and A==B.
module risc_alu
    import risc_pkg::*;
#(
    parameter int WIDTH = RISC_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             shl,
    input  logic             nand_sel,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             zero,
    output logic             eq
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Adder with optional shifted operand, result select and compares
    always_comb begin
        b_eff = shl ? {b[WIDTH-2:0], 1'b0} : b;
        sum   = {1'b0, a} + {1'b0, b_eff};
        cout  = sum[WIDTH];
        res   = nand_sel ? ~(a & b) : sum[WIDTH-1:0];
        zero  = (res == '0);
        eq    = (a == b);
    end
endmodule

// File: rtl/instr_fetch_decode_execute.sv
// IF / ID / EX front end of the 16-bit IITB-RISC pipeline with an internal
// 8x16 register file. Branches and jumps resolve in EX and squash the two
// younger instructions; flush squashes them without touching the PC.
module instr_fetch_decode_execute
    import risc_pkg::*;
#(
    parameter int WIDTH = RISC_WIDTH,
    parameter int NREGS = 8
) (
    input  logic clk,
    input  logic resetn,
    instr_fetch_decode_execute_if.master bus
);
    logic [WIDTH-1:0] pc;

    logic             ifid_vld;
    logic [WIDTH-1:0] ifid_instr;
    logic [WIDTH-1:0] ifid_pc;

    logic             idex_vld;
    alu_op_t          idex_op;
    rij_t             idex_fmt;
    logic [11:0]      idex_i12;
    logic [WIDTH-1:0] idex_pc;

    logic [WIDTH-1:0] regs [NREGS];
    logic             c_reg;
    logic             z_reg;

    logic [2:0]       ex_ra, ex_rb, ex_rc;
    logic [WIDTH-1:0] ex_ra_val, ex_rb_val;
    logic [WIDTH-1:0] alu_b, alu_res;
    logic             alu_shl, alu_nand, alu_cout, alu_zero, alu_eq;

    logic             wr_en, set_c, set_z, redirect;
    logic [2:0]       wr_sel;
    logic [WIDTH-1:0] wr_val, target;
    logic             ex_live, ex_update, ex_redirect, squash;

    function automatic logic [WIDTH-1:0] sext6(input logic [5:0] v);
        return {{(WIDTH-6){v[5]}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] sext9(input logic [8:0] v);
        return {{(WIDTH-9){v[8]}}, v};
    endfunction

    assign ex_ra     = idex_i12[11:9];
    assign ex_rb     = idex_i12[8:6];
    assign ex_rc     = idex_i12[5:3];
    assign ex_ra_val = regs[ex_ra];
    assign ex_rb_val = regs[ex_rb];

    risc_alu #(.WIDTH(WIDTH)) u_alu (
        .a        (ex_ra_val),
        .b        (alu_b),
        .shl      (alu_shl),
        .nand_sel (alu_nand),
        .res      (alu_res),
        .cout     (alu_cout),
        .zero     (alu_zero),
        .eq       (alu_eq)
    );

    // EX: operand select, conditional-execute decisions and branch target
    always_comb begin
        alu_b    = ex_rb_val;
        alu_shl  = 1'b0;
        alu_nand = 1'b0;
        wr_en    = 1'b0;
        wr_sel   = ex_rc;
        wr_val   = alu_res;
        set_c    = 1'b0;
        set_z    = 1'b0;
        redirect = 1'b0;
        target   = idex_pc + sext6(idex_i12[5:0]);
        case (idex_op)
            ALU_ADD: begin wr_en = 1'b1;  set_c = 1'b1;  set_z = 1'b1;  end
            ALU_ADC: begin wr_en = c_reg; set_c = c_reg; set_z = c_reg; end
            ALU_ADZ: begin wr_en = z_reg; set_c = z_reg; set_z = z_reg; end
            ALU_ADL: begin
                alu_shl = 1'b1;
                wr_en   = 1'b1;
                set_c   = 1'b1;
                set_z   = 1'b1;
            end
            ALU_ADI: begin
                alu_b  = sext6(idex_i12[5:0]);
                wr_sel = ex_rb;
                wr_en  = 1'b1;
                set_c  = 1'b1;
                set_z  = 1'b1;
            end
            ALU_NDU: begin alu_nand = 1'b1; wr_en = 1'b1;  set_z = 1'b1;  end
            ALU_NDC: begin alu_nand = 1'b1; wr_en = c_reg; set_z = c_reg; end
            ALU_NDZ: begin alu_nand = 1'b1; wr_en = z_reg; set_z = z_reg; end
            ALU_LHI: begin
                wr_sel = ex_ra;
                wr_val = {idex_i12[8:0], {(WIDTH-9){1'b0}}};
                wr_en  = 1'b1;
            end
            ALU_BEQ: redirect = alu_eq;
            ALU_JAL: begin
                wr_sel   = ex_ra;
                wr_val   = idex_pc + WIDTH'(1);
                wr_en    = 1'b1;
                redirect = 1'b1;
                target   = idex_pc + sext9(idex_i12[8:0]);
            end
            ALU_JLR: begin
                // RB was sampled above, so RA==RB still jumps to the old value
                wr_sel   = ex_ra;
                wr_val   = idex_pc + WIDTH'(1);
                wr_en    = 1'b1;
                redirect = 1'b1;
                target   = ex_rb_val;
            end
            default: ;
        endcase
    end

    assign ex_live     = idex_vld && (idex_fmt != FMT_NOP);
    assign ex_update   = ex_live && wr_en;
    assign ex_redirect = ex_live && redirect;
    assign squash      = ex_redirect || bus.flush;

    // Control: PC sequencing and stage valids
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc       <= '0;
            ifid_vld <= 1'b0;
            idex_vld <= 1'b0;
        end else begin
            pc       <= ex_redirect ? target : pc + WIDTH'(1);
            ifid_vld <= !squash;
            idex_vld <= ifid_vld && !squash;
        end
    end

    // Datapath: IF/ID capture and ID decode into ID/EX
    always_ff @(posedge clk) begin
        ifid_instr <= bus.imem_rdata;
        ifid_pc    <= pc;
        idex_op    <= decode_op(ifid_instr[15:0]);
        idex_fmt   <= decode_fmt(decode_op(ifid_instr[15:0]));
        idex_i12   <= ifid_instr[11:0];
        idex_pc    <= ifid_pc;
    end

    // Write-back of the EX result and flag update
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            c_reg <= 1'b0;
            z_reg <= 1'b0;
        end else begin
            if (ex_update)          regs[wr_sel] <= wr_val;
            if (ex_live && set_c)   c_reg <= alu_cout;
            if (ex_live && set_z)   z_reg <= alu_zero;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.update    = ex_update;
    assign bus.wr_addr   = wr_sel;
    assign bus.wr_data   = wr_val;
    assign bus.c_flag    = c_reg;
    assign bus.z_flag    = z_reg;
    assign bus.dbg_data  = regs[bus.dbg_addr];
endmodule

// File: tb/tb_instr_fetch_decode_execute.sv
// Scoreboard bench: an instruction-level reference model predicts, per cycle,
// the fetch address, the write-back event and the flags; a monitor compares.
module tb_instr_fetch_decode_execute;

    typedef struct packed {
        logic [15:0] pc;
        logic        upd;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        c;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic mon_en = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [15:0] mem [256];
    exp_t        q [$];

    // reference state: architectural registers plus the two squashable slots
    logic [15:0] m_regs [8];
    logic        m_c, m_z;
    logic [15:0] m_pc;
    logic        id_v, ex_v;
    logic [15:0] id_pc, id_ins, ex_pc, ex_ins;

    instr_fetch_decode_execute_if bus ();

    instr_fetch_decode_execute dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #10 clk = ~clk;

    assign bus.imem_rdata = mem[bus.imem_addr[7:0]];

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Architectural effect of one instruction, straight from the ISA rules
    task automatic isa_exec(input logic [15:0] pc, input logic [15:0] ins,
                            output logic we, output logic [2:0] wa, output logic [15:0] wd,
                            output logic nc, output logic nz,
                            output logic redir, output logic [15:0] tgt);
        logic [15:0] a, b, bb, sx6, sx9;
        logic [16:0] s;
        logic        cond;
        a   = m_regs[ins[11:9]];
        b   = m_regs[ins[8:6]];
        sx6 = {{10{ins[5]}}, ins[5:0]};
        sx9 = {{7{ins[8]}}, ins[8:0]};
        we = 0; wa = 0; wd = 0; nc = m_c; nz = m_z; redir = 0; tgt = 0;
        cond = (ins[1:0] == 2'b00) || (ins[1:0] == 2'b10 && m_c) || (ins[1:0] == 2'b01 && m_z);
        case (ins[15:12])
            4'h1: if (cond || ins[1:0] == 2'b11) begin
                bb = (ins[1:0] == 2'b11) ? (b << 1) : b;
                s  = {1'b0, a} + {1'b0, bb};
                we = 1; wa = ins[5:3]; wd = s[15:0]; nc = s[16]; nz = (s[15:0] == 16'h0);
            end
            4'h0: begin
                s  = {1'b0, a} + {1'b0, sx6};
                we = 1; wa = ins[8:6]; wd = s[15:0]; nc = s[16]; nz = (s[15:0] == 16'h0);
            end
            4'h2: if (ins[1:0] != 2'b11 && cond) begin
                wd = ~(a & b); we = 1; wa = ins[5:3]; nz = (wd == 16'h0);
            end
            4'h3: begin we = 1; wa = ins[11:9]; wd = {ins[8:0], 7'b0}; end
            4'h8: if (a == b) begin redir = 1; tgt = pc + sx6; end
            4'h9: begin we = 1; wa = ins[11:9]; wd = pc + 16'd1; redir = 1; tgt = pc + sx9; end
            4'hA: begin we = 1; wa = ins[11:9]; wd = pc + 16'd1; redir = 1; tgt = b; end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_c = 0; m_z = 0; m_pc = 16'h0; id_v = 0; ex_v = 0;
        id_pc = 0; id_ins = 0; ex_pc = 0; ex_ins = 0;
    endtask

    // One clock: predict this cycle, queue it, advance the model, wait an edge
    task automatic step(input logic f);
        exp_t        e;
        logic        we, nc, nz, redir;
        logic [2:0]  wa;
        logic [15:0] wd, tgt;
        bus.flush = f;
        we = 0; wa = 0; wd = 0; nc = m_c; nz = m_z; redir = 0; tgt = 0;
        if (ex_v) isa_exec(ex_pc, ex_ins, we, wa, wd, nc, nz, redir, tgt);
        e.pc = m_pc; e.c = m_c; e.z = m_z;
        e.upd = we; e.wa = wa; e.wd = wd;
        q.push_back(e);
        if (redir || f) begin
            ex_v = 0; id_v = 0;
        end else begin
            ex_v = id_v; ex_pc = id_pc; ex_ins = id_ins;
            id_v = 1; id_pc = m_pc; id_ins = mem[m_pc[7:0]];
        end
        if (we) m_regs[wa] = wd;
        m_c = nc; m_z = nz;
        m_pc = redir ? tgt : m_pc + 16'd1;
        @(posedge clk); #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard: no expectation queued at %0t", $time);
                end else begin
                    e = q.pop_front();
                    if (bus.imem_addr !== e.pc || bus.update !== e.upd ||
                        (e.upd && (bus.wr_addr !== e.wa || bus.wr_data !== e.wd)) ||
                        bus.c_flag !== e.c || bus.z_flag !== e.z) begin
                        n_bad++;
                        $display("FAIL cycle@%0t: got pc=%h upd=%b wa=%0d wd=%h c=%b z=%b, expected pc=%h upd=%b wa=%0d wd=%h c=%b z=%b",
                                 $time, bus.imem_addr, bus.update, bus.wr_addr, bus.wr_data,
                                 bus.c_flag, bus.z_flag, e.pc, e.upd, e.wa, e.wd, e.c, e.z);
                    end
                end
            end
        end
    endtask

    // Assert reset, check the cleared state, release with a fresh program
    task automatic do_reset();
        resetn = 1'b0; mon_en = 1'b0; bus.flush = 1'b0; q.delete();
        #1;
        chk16("reset_pc", bus.imem_addr, 16'h0);
        chk16("reset_update", {15'h0, bus.update}, 16'h0);
        chk16("reset_flags", {14'h0, bus.c_flag, bus.z_flag}, 16'h0);
        for (int i = 0; i < 7; i++) begin
            bus.dbg_addr = 3'(i); #1;
            chk16($sformatf("reset_r%0d", i), bus.dbg_data, 16'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        bus.dbg_addr = 3'd7; #1;
        chk16("reset_r7", bus.dbg_data, 16'h0);
        bus.dbg_addr = 3'd0;
    endtask

    task automatic release_reset();
        model_reset();
        resetn = 1'b1; mon_en = 1'b1;
    endtask

    task automatic check_regs_model();
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i); #1;
            chk16($sformatf("model_r%0d", i), bus.dbg_data, m_regs[i]);
        end
        bus.dbg_addr = 3'd0;
    endtask

    task automatic check_regs_lit(input logic [15:0] want [8]);
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i); #1;
            chk16($sformatf("lit_r%0d", i), bus.dbg_data, want[i]);
        end
        bus.dbg_addr = 3'd0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    initial begin
        logic [15:0] want [8];
        logic [3:0]  ops [10];
        logic [31:0] r;
        fork
            monitor();
        join_none
        bus.flush = 1'b0; bus.dbg_addr = 3'd0;
        fill_nop();
        ops = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hF, 4'h5};
        repeat (2) @(posedge clk);
        #1;

        // arithmetic, carry/zero conditions, NAND
        do_reset();
        mem[0] = 16'h3203; mem[1] = 16'h02BF; mem[2] = 16'h1298; mem[3] = 16'h01FF;
        mem[4] = 16'h33FF; mem[5] = 16'h1250; mem[6] = 16'h125A; mem[7] = 16'h1261;
        mem[8] = 16'h2FE8; mem[9] = 16'h1261;
        release_reset();
        repeat (16) step(1'b0);
        check_regs_model();
        step(1'b0);
        want = '{16'h0000, 16'hFF80, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0000, 16'h0000, 16'hFFFF};
        check_regs_lit(want);
        chk16("prog1_flags", {14'h0, bus.c_flag, bus.z_flag}, 16'h0002);

        // branch, JAL, JLR with RA==RB
        do_reset();
        fill_nop();
        mem[0] = 16'h3203; mem[1] = 16'h02BF; mem[2] = 16'h8003; mem[3] = 16'h00C1;
        mem[4] = 16'h0101; mem[5] = 16'h9C02; mem[6] = 16'h0141; mem[7] = 16'h0142;
        mem[8] = 16'hA240;
        release_reset();
        repeat (16) step(1'b0);
        chk16("prog2_pc", bus.imem_addr, 16'h0180 + 16'd4);
        want = '{16'h0000, 16'h0009, 16'h017F, 16'h0000, 16'h0000, 16'h0002, 16'h0006, 16'h0000};
        check_regs_lit(want);

        // flush with two ADIs in flight
        do_reset();
        fill_nop();
        mem[0] = 16'h0045; mem[1] = 16'h0086; mem[2] = 16'h00C7; mem[3] = 16'h0108;
        mem[4] = 16'h0149;
        release_reset();
        step(1'b0); step(1'b0); step(1'b1);
        repeat (8) step(1'b0);
        want = '{16'h0000, 16'h0005, 16'h0000, 16'h0000, 16'h0008, 16'h0009, 16'h0000, 16'h0000};
        check_regs_lit(want);

        // random programs with random flushes, reset between them
        for (int p = 0; p < 4; p++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                r = $urandom();
                mem[i] = {ops[$urandom_range(0, 9)], r[11:0]};
            end
            release_reset();
            for (int k = 0; k < 300; k++) step($urandom_range(0, 15) == 0);
            check_regs_model();
        end

        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
